clahe_hist_accum: RTL and testbench

CLAHE_HIST_ACCUM -- requirements
Module: clahe_hist_accum

---
 rtl/clahe_hist_accum.sv | 174 +++++++++++++++++
 tb/tb_clahe_hist_accum.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clahe_hist_accum.sv
// CLAHE per-tile histogram accumulator: ping-pong banks, 2-stage
// read-modify-write pipeline with same-bin forwarding and bank clearing.
module clahe_hist_accum (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_pixel,
    input  logic [5:0]  in_tile_idx,
    output logic        ping_pong_flag,
    output logic        clear_start,
    input  logic        clear_done,
    output logic [5:0]  tile_idx,
    output logic [7:0]  rd_addr_b,
    input  logic [15:0] rd_data_b,
    output logic [7:0]  wr_addr_a,
    output logic [15:0] wr_data_a,
    output logic        wr_en_a,
    input  logic        hist_consumed,
    output logic        hist_ready,
    output logic        init_done,
    output logic        err_overrun
);

    typedef enum logic [2:0] {
        INIT0, INIT1, IDLE, ACCUM, DRAIN, SWAP_WAIT
    } state_t;

    typedef enum logic [1:0] {
        C_IDLE, C_START, C_GAP, C_BUSY
    } cstate_t;

    state_t      state;
    cstate_t     cstate;
    logic        init_started;
    logic        pending_consume;
    logic        s1_valid;
    logic        s1_fwd;
    logic [7:0]  s1_bin;
    logic [5:0]  s1_tile;
    logic        fwd_valid;
    logic [15:0] fwd_data;
    logic        accept;
    logic        tile_block;
    logic        init_go;
    logic        consume_go;
    logic [15:0] base;

    // Both RAM ports share tile_idx, so a tile change must wait for S1 to drain.
    always_comb begin
        tile_block = s1_valid && (in_tile_idx != s1_tile);
        in_ready   = rst_n && (state == ACCUM) && !frame_end && !tile_block;
        accept     = in_valid && in_ready;
        base       = (s1_fwd && fwd_valid) ? fwd_data : rd_data_b;
        wr_en_a    = rst_n && s1_valid;
        wr_addr_a  = s1_valid ? s1_bin : 8'd0;
        wr_data_a  = 16'd0;
        if (s1_valid)
            wr_data_a = (base == 16'hFFFF) ? 16'hFFFF : base + 16'd1;
        rd_addr_b  = accept ? in_pixel : 8'd0;
        tile_idx   = 6'd0;
        if (s1_valid)
            tile_idx = s1_tile;
        else if (accept)
            tile_idx = in_tile_idx;
    end

    always_comb begin
        init_go    = (cstate == C_IDLE) && !init_started
                   && ((state == INIT0) || (state == INIT1));
        consume_go = (cstate == C_IDLE) && hist_consumed && pending_consume;
    end

    // A read issued on the same edge as a write to that bin sees stale data.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_fwd    <= 1'b0;
            s1_bin    <= 8'd0;
            s1_tile   <= 6'd0;
            fwd_valid <= 1'b0;
            fwd_data  <= 16'd0;
        end else begin
            s1_valid  <= accept;
            s1_fwd    <= accept && s1_valid
                       && (in_pixel == s1_bin) && (in_tile_idx == s1_tile);
            if (accept) begin
                s1_bin  <= in_pixel;
                s1_tile <= in_tile_idx;
            end
            fwd_valid <= wr_en_a;
            if (wr_en_a)
                fwd_data <= wr_data_a;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state           <= INIT0;
            cstate          <= C_IDLE;
            init_started    <= 1'b0;
            pending_consume <= 1'b0;
            ping_pong_flag  <= 1'b0;
            clear_start     <= 1'b0;
            hist_ready      <= 1'b0;
            init_done       <= 1'b0;
            err_overrun     <= 1'b0;
        end else begin
            clear_start <= 1'b0;
            hist_ready  <= 1'b0;
            unique case (cstate)
                C_START: cstate <= C_GAP;
                C_GAP:   cstate <= C_BUSY;
                C_BUSY:  if (clear_done) cstate <= C_IDLE;
                default: ;
            endcase
            if (init_go || consume_go) begin
                cstate      <= C_START;
                clear_start <= 1'b1;
            end
            if (consume_go)
                pending_consume <= 1'b0;
            unique case (state)
                INIT0: begin
                    if (!init_started) begin
                        init_started <= 1'b1;
                    end else if (cstate == C_IDLE) begin
                        init_started   <= 1'b0;
                        ping_pong_flag <= 1'b1;
                        state          <= INIT1;
                    end
                end
                INIT1: begin
                    if (!init_started) begin
                        init_started <= 1'b1;
                    end else if (cstate == C_IDLE) begin
                        init_started   <= 1'b0;
                        ping_pong_flag <= 1'b0;
                        init_done      <= 1'b1;
                        state          <= IDLE;
                    end
                end
                IDLE: begin
                    if (frame_start)
                        state <= ACCUM;
                end
                ACCUM: begin
                    if (frame_end)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (frame_start)
                        err_overrun <= 1'b1;
                    if (!s1_valid)
                        state <= SWAP_WAIT;
                end
                SWAP_WAIT: begin
                    if (frame_start)
                        err_overrun <= 1'b1;
                    if (!pending_consume && (cstate == C_IDLE)) begin
                        ping_pong_flag  <= ~ping_pong_flag;
                        hist_ready      <= 1'b1;
                        pending_consume <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= INIT0;
            endcase
        end
    end

endmodule

// File: tb/tb_clahe_hist_accum.sv
// Directed bench for clahe_hist_accum with a behavioural two-bank
// histogram RAM and a 256-cycle clearer model.
module tb_clahe_hist_accum;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        frame_end;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pixel;
    logic [5:0]  in_tile_idx;
    logic        ping_pong_flag;
    logic        clear_start;
    logic        clear_done;
    logic [5:0]  tile_idx;
    logic [7:0]  rd_addr_b;
    logic [15:0] rd_data_b;
    logic [7:0]  wr_addr_a;
    logic [15:0] wr_data_a;
    logic        wr_en_a;
    logic        hist_consumed;
    logic        hist_ready;
    logic        init_done;
    logic        err_overrun;

    logic [15:0] mem [0:32767];
    int          clr_cnt = 0;
    logic        pre_en = 1'b0;
    logic [14:0] pre_addr = 15'd0;
    logic [15:0] pre_data = 16'd0;

    int total = 0;
    int bad = 0;

    always #5 pclk = ~pclk;

    clahe_hist_accum dut (
        .pclk(pclk),
        .rst_n(rst_n),
        .frame_start(frame_start),
        .frame_end(frame_end),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pixel(in_pixel),
        .in_tile_idx(in_tile_idx),
        .ping_pong_flag(ping_pong_flag),
        .clear_start(clear_start),
        .clear_done(clear_done),
        .tile_idx(tile_idx),
        .rd_addr_b(rd_addr_b),
        .rd_data_b(rd_data_b),
        .wr_addr_a(wr_addr_a),
        .wr_data_a(wr_data_a),
        .wr_en_a(wr_en_a),
        .hist_consumed(hist_consumed),
        .hist_ready(hist_ready),
        .init_done(init_done),
        .err_overrun(err_overrun)
    );

    assign clear_done = (clr_cnt == 0);

    // RAM: read-before-write, the clear wipes the idle bank at once
    always @(posedge pclk) begin
        rd_data_b <= mem[{ping_pong_flag, tile_idx, rd_addr_b}];
        if (wr_en_a)
            mem[{ping_pong_flag, tile_idx, wr_addr_a}] = wr_data_a;
        if (pre_en)
            mem[pre_addr] = pre_data;
        if (clear_start) begin
            for (int i = 0; i < 16384; i++)
                mem[{~ping_pong_flag, i[13:0]}] = 16'd0;
            clr_cnt <= 256;
        end else if (clr_cnt != 0) begin
            clr_cnt <= clr_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge pclk);
        #1;
    endtask

    task automatic init_seq(input string tag);
        int pulses = 0;
        int n = 0;
        int ir_hi = 0;
        logic f0 = 1'b1;
        logic f1 = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge pclk);
            n++;
            if (in_ready) ir_hi++;
            if (clear_start) begin
                if (pulses == 0) f0 = ping_pong_flag;
                else f1 = ping_pong_flag;
                pulses++;
            end
            if (init_done) break;
        end
        check({tag, "_done"}, {31'd0, init_done}, 1);
        check({tag, "_pulses"}, pulses, 2);
        check({tag, "_flag_clr1"}, {31'd0, f0}, 0);
        check({tag, "_flag_clr2"}, {31'd0, f1}, 1);
        check({tag, "_flag_end"}, {31'd0, ping_pong_flag}, 0);
        check({tag, "_cycles"}, {31'd0, (n >= 500 && n <= 560)}, 1);
        check({tag, "_rdy_low"}, ir_hi, 0);
    endtask

    initial begin
        int lows;
        int k;
        int pulses;
        rst_n = 1'b0;
        frame_start = 1'b0;
        frame_end = 1'b0;
        in_valid = 1'b1;
        in_pixel = 8'd0;
        in_tile_idx = 6'd0;
        hist_consumed = 1'b0;
        repeat (3) cyc();
        @(negedge pclk);
        check("rst_ready", {31'd0, in_ready}, 0);
        check("rst_wren", {31'd0, wr_en_a}, 0);
        check("rst_clr", {31'd0, clear_start}, 0);
        check("rst_init", {31'd0, init_done}, 0);
        check("rst_flag", {31'd0, ping_pong_flag}, 0);
        check("rst_err", {31'd0, err_overrun}, 0);
        check("rst_tile", {26'd0, tile_idx}, 0);
        check("rst_rdaddr", {24'd0, rd_addr_b}, 0);

        cyc();
        rst_n = 1'b1;
        init_seq("init");
        in_valid = 1'b0;

        // same bin back-to-back
        cyc();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        in_valid = 1'b1;
        in_pixel = 8'd37;
        in_tile_idx = 6'd5;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            @(negedge pclk);
            check("b2b_ready", {31'd0, in_ready}, 1);
            check("b2b_rdaddr", {24'd0, rd_addr_b}, 37);
            if (i > 0) begin
                check("b2b_wren", {31'd0, wr_en_a}, 1);
                check("b2b_addr", {24'd0, wr_addr_a}, 37);
                check("b2b_data", {16'd0, wr_data_a}, i);
            end else begin
                check("b2b_wren0", {31'd0, wr_en_a}, 0);
            end
        end
        cyc();
        in_valid = 1'b0;
        @(negedge pclk);
        check("b2b_wren", {31'd0, wr_en_a}, 1);
        check("b2b_data4", {16'd0, wr_data_a}, 4);
        check("b2b_tile", {26'd0, tile_idx}, 5);
        cyc();
        @(negedge pclk);
        check("s1_empty_wren", {31'd0, wr_en_a}, 0);
        check("s1_empty_tile", {26'd0, tile_idx}, 0);

        // tile change bubble
        lows = 0;
        cyc();
        in_valid = 1'b1;
        in_pixel = 8'd100;
        in_tile_idx = 6'd3;
        @(negedge pclk);
        if (!in_ready) lows++;
        cyc();
        in_pixel = 8'd101;
        in_tile_idx = 6'd4;
        @(negedge pclk);
        if (!in_ready) lows++;
        check("tc_wr_addr", {24'd0, wr_addr_a}, 100);
        check("tc_wr_data", {16'd0, wr_data_a}, 1);
        check("tc_wr_tile", {26'd0, tile_idx}, 3);
        cyc();
        @(negedge pclk);
        if (!in_ready) lows++;
        cyc();
        in_valid = 1'b0;
        @(negedge pclk);
        if (!in_ready) lows++;
        check("tc_wr_addr2", {24'd0, wr_addr_a}, 101);
        check("tc_wr_data2", {16'd0, wr_data_a}, 1);
        check("tc_bubbles", lows, 1);
        cyc();
        check("tc_bin3", {16'd0, mem[{1'b0, 6'd3, 8'd100}]}, 1);
        check("tc_bin4", {16'd0, mem[{1'b0, 6'd4, 8'd101}]}, 1);
        check("b2b_bin", {16'd0, mem[{1'b0, 6'd5, 8'd37}]}, 4);

        // saturation
        pre_en = 1'b1;
        pre_addr = {1'b0, 6'd0, 8'd9};
        pre_data = 16'hFFFF;
        cyc();
        pre_en = 1'b0;
        in_valid = 1'b1;
        in_pixel = 8'd9;
        in_tile_idx = 6'd0;
        cyc();
        in_valid = 1'b0;
        @(negedge pclk);
        check("sat_wren", {31'd0, wr_en_a}, 1);
        check("sat_data", {16'd0, wr_data_a}, 16'hFFFF);
        cyc();

        // frame_end wins over in_valid, then swap
        cyc();
        frame_end = 1'b1;
        in_valid = 1'b1;
        in_pixel = 8'd50;
        @(negedge pclk);
        check("fe_ready", {31'd0, in_ready}, 0);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            frame_end = 1'b0;
            in_valid = 1'b0;
            @(negedge pclk);
            if (hist_ready) begin
                k = i;
                break;
            end
        end
        check("swap_latency", {31'd0, (k >= 2 && k <= 3)}, 1);
        check("swap_flag", {31'd0, ping_pong_flag}, 1);
        check("fe_no_write", {16'd0, mem[{1'b0, 6'd0, 8'd50}]}, 0);
        cyc();
        @(negedge pclk);
        check("hr_pulse", {31'd0, hist_ready}, 0);

        // second frame into bank B, no consume
        cyc();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        in_valid = 1'b1;
        in_pixel = 8'd7;
        in_tile_idx = 6'd1;
        cyc();
        in_valid = 1'b0;
        cyc();
        frame_end = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            frame_end = 1'b0;
            @(negedge pclk);
            if (hist_ready) pulses++;
        end
        check("sw_wait_hr", pulses, 0);
        check("sw_wait_flag", {31'd0, ping_pong_flag}, 1);
        check("bankb_bin", {16'd0, mem[{1'b1, 6'd1, 8'd7}]}, 1);

        // third frame overruns
        cyc();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        in_valid = 1'b1;
        @(negedge pclk);
        check("ovr_err", {31'd0, err_overrun}, 1);
        check("ovr_ready", {31'd0, in_ready}, 0);
        cyc();
        in_valid = 1'b0;
        frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
        hist_consumed = 1'b1;
        cyc();
        hist_consumed = 1'b0;
        k = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge pclk);
            if (hist_ready) begin
                k = 1;
                break;
            end
            cyc();
        end
        check("consume_hr", k, 1);
        check("consume_flag", {31'd0, ping_pong_flag}, 0);
        check("err_sticky", {31'd0, err_overrun}, 1);
        check("cleared_a", {16'd0, mem[{1'b0, 6'd5, 8'd37}]}, 0);

        // reset mid-accumulation
        cyc();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        in_valid = 1'b1;
        in_pixel = 8'd20;
        in_tile_idx = 6'd2;
        cyc();
        in_valid = 1'b0;
        @(negedge pclk);
        check("mid_wren", {31'd0, wr_en_a}, 1);
        cyc();
        rst_n = 1'b0;
        @(negedge pclk);
        check("mrst_wren", {31'd0, wr_en_a}, 0);
        check("mrst_ready", {31'd0, in_ready}, 0);
        cyc();
        @(negedge pclk);
        check("mrst_wren2", {31'd0, wr_en_a}, 0);
        check("mrst_init", {31'd0, init_done}, 0);
        check("mrst_err", {31'd0, err_overrun}, 0);
        cyc();
        rst_n = 1'b1;
        init_seq("reinit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
